// File: rtl/uart_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_if
//   Host-side bundle of the UART transmit scheduler: per-requester byte
//   streams plus the clock-divider change request.
//
//   master : host bridges (drive requests, observe ready/grant/busy)
//   slave  : the scheduler
//
//   req_valid[NUM_REQ]   byte available, held until req_ready
//   req_byte[8*NUM_REQ]  byte of requester i in bits [8i+7:8i]
//   req_last[NUM_REQ]    byte closes its packet
//   req_ready[NUM_REQ]   one-cycle consume pulse
//   grant_id[3]          current / last granted requester
//   busy                 scheduler not idle
//   cfg_div_valid        divider change request, held until cfg_div_ready
//   cfg_div[32]          new divider
//   cfg_div_ready        one-cycle pulse: divider applied
// ---------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [2:0]           grant_id;
    logic                 busy;
    logic                 cfg_div_valid;
    logic [31:0]          cfg_div;
    logic                 cfg_div_ready;

    modport master (
        output req_valid, req_byte, req_last, cfg_div_valid, cfg_div,
        input  req_ready, grant_id, busy, cfg_div_ready
    );

    modport slave (
        input  req_valid, req_byte, req_last, cfg_div_valid, cfg_div,
        output req_ready, grant_id, busy, cfg_div_ready
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one UART transmitter among NUM_REQ byte-stream requesters.
//   Round-robin arbitration, grant held for a whole packet (bounded by
//   MAX_BURST bytes), and baud divider changes applied only while the
//   transmitter is idle.
//
//   clk, rst               clock, synchronous active-high reset
//   bus (slave)            requester streams + divider change handshake
//   uart_transmit          one-cycle start pulse to the UART
//   uart_tx_byte[8]        byte presented with uart_transmit
//   uart_is_transmitting   UART line busy
//   uart_set_clock_div     one-cycle divider load strobe
//   uart_user_clock_div[32] divider value for the UART
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_scheduler_if.slave bus,
    output logic               uart_transmit,
    output logic [7:0]         uart_tx_byte,
    input  logic               uart_is_transmitting,
    output logic               uart_set_clock_div,
    output logic [31:0]        uart_user_clock_div
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, CFG} state_t;

    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    state_t               state_reg, state_next;
    logic [2:0]           grant_id_reg, grant_id_next;
    logic [7:0]           burst_cnt_reg, burst_cnt_next;
    logic                 last_q_reg, last_q_next;

    logic [NUM_REQ-1:0]   req_ready_reg;
    logic                 transmit_reg, transmit_next;
    logic [7:0]           tx_byte_reg, tx_byte_next;
    logic                 set_div_reg, set_div_next;
    logic [31:0]          user_div_reg, user_div_next;
    logic                 cfg_ready_reg, cfg_ready_next;
    logic                 busy_reg;

    // Requester signals widened to 8 slots so a 3-bit index always fits.
    logic [7:0]           valid_pad;
    logic [7:0]           last_pad;
    logic [7:0]           byte_pad [8];
    logic [NUM_REQ-1:0]   ready_vec;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < NUM_REQ) begin : g_used
                assign valid_pad[gi] = bus.req_valid[gi];
                assign last_pad[gi]  = bus.req_last[gi];
                assign byte_pad[gi]  = bus.req_byte[8*gi +: 8];
            end else begin : g_unused
                assign valid_pad[gi] = 1'b0;
                assign last_pad[gi]  = 1'b0;
                assign byte_pad[gi]  = 8'h00;
            end
        end
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == ISSUE) && (grant_id_reg == 3'(gi));
        end
    endgenerate

    // Round-robin search: first valid requester after the last grant,
    // wrapping; the last grantee is checked last, so a lone requester is
    // re-granted.
    logic       arb_found;
    logic [2:0] arb_idx;
    logic [3:0] cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = grant_id_reg;
        cand      = 4'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, grant_id_reg} + 4'(k);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            if (!arb_found && valid_pad[cand[2:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_id_next  = grant_id_reg;
        burst_cnt_next = burst_cnt_reg;
        last_q_next    = last_q_reg;
        transmit_next  = 1'b0;
        tx_byte_next   = tx_byte_reg;
        set_div_next   = 1'b0;
        cfg_ready_next = 1'b0;
        user_div_next  = user_div_reg;

        case (state_reg)
            IDLE: begin
                if (!uart_is_transmitting) begin
                    // The host still holds cfg_div_valid in the cycle it
                    // sees cfg_div_ready; ignore it then so the same
                    // request is not applied twice.
                    if (bus.cfg_div_valid && !cfg_ready_reg) begin
                        state_next = CFG;
                    end else if (arb_found) begin
                        grant_id_next  = arb_idx;
                        burst_cnt_next = 8'd1;
                        state_next     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                transmit_next = 1'b1;
                tx_byte_next  = byte_pad[grant_id_reg];
                last_q_next   = last_pad[grant_id_reg];
                state_next    = WAIT_START;
            end
            WAIT_START: begin
                if (uart_is_transmitting) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    if (!last_q_reg && (burst_cnt_reg < BURST_LIMIT) &&
                        valid_pad[grant_id_reg] && !bus.cfg_div_valid) begin
                        burst_cnt_next = burst_cnt_reg + 8'd1;
                        state_next     = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            CFG: begin
                user_div_next  = bus.cfg_div;
                set_div_next   = 1'b1;
                cfg_ready_next = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            grant_id_reg  <= 3'(NUM_REQ - 1);
            burst_cnt_reg <= 8'd0;
            last_q_reg    <= 1'b0;
            req_ready_reg <= '0;
            transmit_reg  <= 1'b0;
            tx_byte_reg   <= 8'h00;
            set_div_reg   <= 1'b0;
            user_div_reg  <= 32'd0;
            cfg_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_id_reg  <= grant_id_next;
            burst_cnt_reg <= burst_cnt_next;
            last_q_reg    <= last_q_next;
            req_ready_reg <= ready_vec;
            transmit_reg  <= transmit_next;
            tx_byte_reg   <= tx_byte_next;
            set_div_reg   <= set_div_next;
            user_div_reg  <= user_div_next;
            cfg_ready_reg <= cfg_ready_next;
            // Registered from the next state so busy tracks state exactly.
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign bus.req_ready        = req_ready_reg;
    assign bus.grant_id         = grant_id_reg;
    assign bus.busy             = busy_reg;
    assign bus.cfg_div_ready    = cfg_ready_reg;
    assign uart_transmit        = transmit_reg;
    assign uart_tx_byte         = tx_byte_reg;
    assign uart_set_clock_div   = set_div_reg;
    assign uart_user_clock_div  = user_div_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//   Self-checking bench: requester byte queues, a UART timing model,
//   a table of arbitration vectors, hand-written burst/config/reset
//   sequences and randomized packet mixes checked against a packet-level
//   round-robin reference model.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;
    localparam int NR = 4;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic        uart_is_transmitting;
    logic        uart_set_clock_div;
    logic [31:0] uart_user_clock_div;

    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(NR)) bus();

    uart_tx_scheduler #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .uart_set_clock_div   (uart_set_clock_div),
        .uart_user_clock_div  (uart_user_clock_div)
    );

    typedef struct packed {
        logic [2:0] id;
        logic [7:0] b;
    } txn_t;

    typedef struct {
        logic [3:0] mask;
        logic [2:0] g;
    } vec_t;

    txn_t       log_q[$];
    txn_t       exp_q[$];
    logic [8:0] rq [NR][$];   // bench requester queues {last, byte}
    logic [8:0] mq [NR][$];   // reference-model copies

    int   n_cmp = 0;
    int   n_fail = 0;
    logic uart_pending;
    int   uart_cnt;
    int   uart_len;
    bit   tx_seen;
    bit   uart_fell;
    int   cfg_pulses;
    int   cfg_pulse_txcount;
    logic cfg_pulse_uart_busy;
    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bit queues_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic drive_inputs();
        logic [NR-1:0]   v;
        logic [NR-1:0]   l;
        logic [8*NR-1:0] b;
        v = '0;
        l = '0;
        b = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() > 0) begin
                v[i]       = 1'b1;
                b[8*i +: 8] = rq[i][0][7:0];
                l[i]       = rq[i][0][8];
            end
        end
        bus.req_valid = v;
        bus.req_byte  = b;
        bus.req_last  = l;
    endtask

    // One clock: observe DUT outputs after the edge, advance the UART
    // model and requesters, then drive the next inputs.
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        tx_seen   = 1'b0;
        uart_fell = 1'b0;

        if (uart_transmit) begin
            tx_seen = 1'b1;
            check("tx_while_uart_busy", 64'({uart_pending, uart_is_transmitting}), 64'(0));
            log_q.push_back({bus.grant_id, uart_tx_byte});
            $display("tx: grant=%0d byte=%02h t=%0t", bus.grant_id, uart_tx_byte, $time);
        end

        if (bus.req_ready != '0 || uart_transmit) begin
            check("ready_with_transmit", 64'({$onehot(bus.req_ready), uart_transmit}), 64'(2'b11));
            if ($onehot(bus.req_ready)) begin
                idx = 0;
                for (int i = 0; i < NR; i++) begin
                    if (bus.req_ready[i]) idx = i;
                end
                check("grant_matches_ready", 64'(bus.grant_id), 64'(idx));
                if (rq[idx].size() > 0) begin
                    check("tx_byte", 64'(uart_tx_byte), 64'(rq[idx][0][7:0]));
                    void'(rq[idx].pop_front());
                end else begin
                    check("ready_on_empty", 64'(rq[idx].size()), 64'(1));
                end
            end
        end

        if (uart_set_clock_div || bus.cfg_div_ready) begin
            check("cfg_pulse_pair", 64'({uart_set_clock_div, bus.cfg_div_ready}), 64'(2'b11));
            cfg_pulses++;
            cfg_pulse_txcount   = log_q.size();
            cfg_pulse_uart_busy = uart_is_transmitting | uart_pending;
            bus.cfg_div_valid   = 1'b0;
        end

        // UART: is_transmitting rises one clock after transmit, lasts uart_len.
        if (uart_cnt > 0) begin
            uart_cnt--;
            if (uart_cnt == 0) begin
                uart_is_transmitting = 1'b0;
                uart_fell            = 1'b1;
            end
        end
        if (uart_pending) begin
            uart_is_transmitting = 1'b1;
            uart_cnt             = uart_len;
            uart_pending         = 1'b0;
        end
        if (uart_transmit) uart_pending = 1'b1;

        drive_inputs();
    endtask

    task automatic run_until_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 4000 && !done; k++) begin
            tick();
            if (queues_empty() && !bus.busy && !uart_is_transmitting &&
                !uart_pending && !bus.cfg_div_valid) done = 1'b1;
        end
        check({"idle_timeout_", name}, 64'(done), 64'(1));
    endtask

    task automatic wait_log(input int n, input string name);
        bit done;
        done = (log_q.size() >= n);
        for (int k = 0; k < 2000 && !done; k++) begin
            tick();
            if (log_q.size() >= n) done = 1'b1;
        end
        check({"log_timeout_", name}, 64'(done), 64'(1));
    endtask

    task automatic compare_log(input string name);
        int n;
        check({name, "_count"}, 64'(log_q.size()), 64'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_txn%0d", name, i), 64'(log_q[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NR; i++) rq[i].delete();
        bus.cfg_div_valid = 1'b0;
        drive_inputs();
        tick();
        tick();
        rst = 1'b0;
        log_q.delete();
    endtask

    // Packet-level reference: round-robin over non-empty queues starting
    // after the previous grantee; a grant ends at a last byte, after MB
    // bytes, or when the requester runs dry.
    task automatic build_expected();
        int         p;
        int         c;
        int         sent;
        bit         any;
        logic [8:0] e;
        exp_q.delete();
        p = NR - 1;
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            c = 0;
            for (int k = 1; k <= NR; k++) begin
                if (!any && mq[(p + k) % NR].size() > 0) begin
                    any = 1'b1;
                    c   = (p + k) % NR;
                end
            end
            if (any) begin
                sent = 0;
                do begin
                    e = mq[c].pop_front();
                    exp_q.push_back({3'(c), e[7:0]});
                    sent++;
                end while (!e[8] && sent < MB && mq[c].size() > 0);
                p = c;
            end
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1);
    end

    initial begin
        int lat;
        bit got;
        int npk;
        int plen;
        logic [8:0] e;

        // Arbitration vectors, starting from the reset pointer (3).
        tbl[0]  = '{4'b1111, 3'd0};
        tbl[1]  = '{4'b1111, 3'd1};
        tbl[2]  = '{4'b1111, 3'd2};
        tbl[3]  = '{4'b1111, 3'd3};
        tbl[4]  = '{4'b1111, 3'd0};
        tbl[5]  = '{4'b1111, 3'd1};
        tbl[6]  = '{4'b1111, 3'd2};
        tbl[7]  = '{4'b1111, 3'd3};
        tbl[8]  = '{4'b0100, 3'd2};
        tbl[9]  = '{4'b1010, 3'd3};
        tbl[10] = '{4'b1010, 3'd1};
        tbl[11] = '{4'b1010, 3'd3};
        tbl[12] = '{4'b0001, 3'd0};
        tbl[13] = '{4'b0110, 3'd1};
        tbl[14] = '{4'b1001, 3'd3};

        rst                  = 1'b1;
        uart_is_transmitting = 1'b0;
        uart_pending         = 1'b0;
        uart_cnt             = 0;
        uart_len             = 3;
        cfg_pulses           = 0;
        cfg_pulse_txcount    = 0;
        cfg_pulse_uart_busy  = 1'b0;
        bus.cfg_div_valid    = 1'b0;
        bus.cfg_div          = 32'd0;
        drive_inputs();
        tick();
        tick();

        // Reset state
        check("rst_uart_outputs", 64'({uart_transmit, uart_tx_byte, uart_set_clock_div}), 64'(0));
        check("rst_user_div", 64'(uart_user_clock_div), 64'(0));
        check("rst_ready", 64'({bus.req_ready, bus.cfg_div_ready}), 64'(0));
        check("rst_grant", 64'(bus.grant_id), 64'(3));
        check("rst_busy", 64'(bus.busy), 64'(0));
        rst = 1'b0;
        tick();

        // Single byte: latency, ready alignment, busy release
        log_q.delete();
        rq[0].push_back({1'b1, 8'h55});
        drive_inputs();
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            tick();
            if (tx_seen) begin
                lat = k;
                check("s1_ready", 64'(bus.req_ready), 64'(4'b0001));
                check("s1_byte", 64'(uart_tx_byte), 64'(8'h55));
                check("s1_grant", 64'(bus.grant_id), 64'(0));
            end
        end
        check("s1_latency", 64'(lat), 64'(2));
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            tick();
            if (uart_fell) got = 1'b1;
        end
        check("s1_uart_fell", 64'(got), 64'(1));
        check("s1_busy_before", 64'(bus.busy), 64'(1));
        tick();
        check("s1_busy_after", 64'(bus.busy), 64'(0));

        // Table-driven arbitration
        do_reset();
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (tbl[t].mask[i]) rq[i].push_back({1'b1, 8'hA0 + 8'(i)});
            end
            drive_inputs();
            got = 1'b0;
            for (int k = 0; k < 200 && !got; k++) begin
                tick();
                if (tx_seen) begin
                    got = 1'b1;
                    check($sformatf("arb%0d_grant", t), 64'(bus.grant_id), 64'(tbl[t].g));
                    check($sformatf("arb%0d_byte", t), 64'(uart_tx_byte), 64'(8'hA0 + 8'(tbl[t].g)));
                end
            end
            check($sformatf("arb%0d_timeout", t), 64'(got), 64'(1));
            for (int i = 0; i < NR; i++) rq[i].delete();
            drive_inputs();
            run_until_idle("arb");
        end

        // Multi-byte packet keeps the grant; requester 1 arrives mid-packet
        log_q.delete();
        rq[2].push_back({1'b0, 8'h2A});
        rq[2].push_back({1'b0, 8'h2B});
        rq[2].push_back({1'b1, 8'h2C});
        drive_inputs();
        wait_log(1, "pkt");
        rq[1].push_back({1'b1, 8'h11});
        drive_inputs();
        run_until_idle("pkt");
        exp_q.delete();
        exp_q.push_back({3'd2, 8'h2A});
        exp_q.push_back({3'd2, 8'h2B});
        exp_q.push_back({3'd2, 8'h2C});
        exp_q.push_back({3'd1, 8'h11});
        compare_log("pkt");

        // MAX_BURST forced re-arbitration
        do_reset();
        for (int k = 0; k < 10; k++) rq[0].push_back({1'b0, 8'(k)});
        rq[3].push_back({1'b1, 8'h3F});
        drive_inputs();
        run_until_idle("burst");
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back({3'd0, 8'(k)});
        exp_q.push_back({3'd3, 8'h3F});
        for (int k = 4; k < 10; k++) exp_q.push_back({3'd0, 8'(k)});
        compare_log("burst");

        // Divider change during a burst
        log_q.delete();
        cfg_pulses = 0;
        for (int k = 0; k < 5; k++) rq[1].push_back({(k == 4), 8'h61 + 8'(k)});
        drive_inputs();
        wait_log(2, "cfg");
        bus.cfg_div       = 32'h36;
        bus.cfg_div_valid = 1'b1;
        run_until_idle("cfg");
        check("cfg_pulse_count", 64'(cfg_pulses), 64'(1));
        check("cfg_after_byte2", 64'(cfg_pulse_txcount), 64'(2));
        check("cfg_uart_idle", 64'(cfg_pulse_uart_busy), 64'(0));
        check("cfg_user_div", 64'(uart_user_clock_div), 64'(32'h36));
        exp_q.delete();
        for (int k = 0; k < 5; k++) exp_q.push_back({3'd1, 8'h61 + 8'(k)});
        compare_log("cfg");

        // Reset while waiting for a byte to finish, 2 bytes pending
        log_q.delete();
        uart_len = 6;
        for (int k = 0; k < 4; k++) rq[2].push_back({(k == 3), 8'hC1 + 8'(k)});
        drive_inputs();
        wait_log(2, "mid_rst");
        got = uart_is_transmitting;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            got = uart_is_transmitting;
        end
        check("mid_rst_uart_busy", 64'(got), 64'(1));
        tick();
        rst = 1'b1;
        rq[0].push_back({1'b1, 8'h0A});
        drive_inputs();
        tick();
        check("mid_rst_uart_outputs", 64'({uart_transmit, uart_tx_byte, uart_set_clock_div}), 64'(0));
        check("mid_rst_user_div", 64'(uart_user_clock_div), 64'(0));
        check("mid_rst_ready", 64'({bus.req_ready, bus.cfg_div_ready}), 64'(0));
        check("mid_rst_grant", 64'(bus.grant_id), 64'(3));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        tick();
        tick();
        check("mid_rst_pending", 64'(rq[2].size()), 64'(2));
        rst = 1'b0;
        log_q.delete();
        run_until_idle("mid_rst");
        exp_q.delete();
        exp_q.push_back({3'd0, 8'h0A});
        exp_q.push_back({3'd2, 8'hC3});
        exp_q.push_back({3'd2, 8'hC4});
        compare_log("mid_rst");
        uart_len = 3;

        // Randomized packet mixes against the reference model
        for (int r = 0; r < 12; r++) begin
            do_reset();
            uart_len = $urandom_range(1, 5);
            for (int i = 0; i < NR; i++) begin
                mq[i].delete();
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    plen = $urandom_range(1, 6);
                    for (int j = 0; j < plen; j++) begin
                        e = {(j == plen - 1), 8'($urandom)};
                        rq[i].push_back(e);
                        mq[i].push_back(e);
                    end
                end
            end
            build_expected();
            drive_inputs();
            run_until_idle($sformatf("rand%0d", r));
            compare_log($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
